mole_sequencer: RTL and testbench

Game timing and pattern source that sits directly upstream of the mole/score stage. Owns the round state machine (idle, play, game over) and generates four things for that stage: the per-interval mole strobe, the reaction-time cycle count, the idle-animation step, and the pseudo-random mole pattern. The pattern comes from a free-running 10-bit LFSR.

---
 rtl/mole_sequencer_if.sv | 22 ++
 rtl/mole_sequencer.sv | 151 +++++++++++++++
 tb/tb_mole_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mole_sequencer_if.sv
// Bundle between the mole sequencer and the downstream mole/score stage.
// The master side is the sequencer; the slave side is the consumer that drives the start button.
interface mole_sequencer_if;
    logic        go;
    logic        mole_clk;
    logic [27:0] count;
    logic [3:0]  idle;
    logic [9:0]  random;
    logic        active;
    logic        done;
    logic [7:0]  rounds_left;

    modport master (
        input  go,
        output mole_clk, count, idle, random, active, done, rounds_left
    );

    modport slave (
        output go,
        input  mole_clk, count, idle, random, active, done, rounds_left
    );
endinterface

// File: rtl/mole_sequencer.sv
// Round FSM (idle/play/over), mole interval timer, idle animation and 10-bit LFSR pattern source.
// Build macro MOLE_SPARSE_EN selects the ~25%-density mole pattern; undefined gives the raw LFSR.
module mole_sequencer #(
    parameter int         PERIOD   = 100_000_000,
    parameter int         IDLE_DIV = 5_000_000,
    parameter int         ROUNDS   = 30,
    parameter logic [9:0] SEED     = 10'h2A5
) (
    input  logic             clk,
    input  logic             rst,
    mole_sequencer_if.master bus
);
    localparam logic [27:0]      CNT_MAX     = 28'(PERIOD - 1);
    localparam int               DIV_W       = (IDLE_DIV > 1) ? $clog2(IDLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX     = DIV_W'(IDLE_DIV - 1);
    localparam logic [7:0]       ROUNDS_INIT = 8'(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_OVER
    } state_e;

    state_e           state_q, state_d;
    logic             go_s_q, go_q;
    logic             go_start;
    logic [9:0]       lfsr_q, lfsr_d;
    logic [9:0]       pat;
    logic [DIV_W-1:0] div_q, div_d;
    logic [27:0]      count_q, count_d;
    logic [3:0]       idle_q, idle_d;
    logic [9:0]       random_q, random_d;
    logic             mole_clk_q, mole_clk_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic [7:0]       rounds_q, rounds_d;

    // go is sampled into go_s_q first, so the game starts two edges after go is seen high.
    assign go_start = go_s_q & ~go_q;

    assign lfsr_d = (lfsr_q == '0) ? SEED : {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

`ifdef MOLE_SPARSE_EN
    logic [9:0] sparse;
    logic [3:0] pick;

    assign sparse = lfsr_q & {lfsr_q[4:0], lfsr_q[9:5]};
    assign pick   = lfsr_q[3:0] % 4'd10;
    assign pat    = (sparse != '0) ? sparse : (10'b1 << pick);
`else
    assign pat = lfsr_q;
`endif

    always_comb begin
        // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        div_d      = div_q;
        count_d    = count_q;
        idle_d     = idle_q;
        random_d   = random_q;
        mole_clk_d = 1'b0;
        active_d   = active_q;
        done_d     = 1'b0;
        rounds_d   = rounds_q;

        unique case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (go_start) begin
                    state_d    = S_PLAY;
                    mole_clk_d = 1'b1;
                    random_d   = pat;
                    rounds_d   = ROUNDS_INIT - 8'd1;
                    active_d   = 1'b1;
                    div_d      = '0;
                end else if (div_q == DIV_MAX) begin
                    div_d  = '0;
                    idle_d = (idle_q == 4'd9) ? 4'd0 : idle_q + 4'd1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_PLAY: begin
                if (count_q == CNT_MAX) begin
                    count_d = '0;
                    if (rounds_q != '0) begin
                        mole_clk_d = 1'b1;
                        random_d   = pat;
                        rounds_d   = rounds_q - 8'd1;
                    end else begin
                        state_d  = S_OVER;
                        done_d   = 1'b1;
                        active_d = 1'b0;
                        random_d = '0;
                    end
                end else begin
                    count_d = count_q + 28'd1;
                end
            end
            S_OVER: begin
                count_d  = '0;
                random_d = '0;
                if (go_start) begin
                    state_d = S_IDLE;
                    idle_d  = '0;
                    div_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            go_s_q     <= 1'b1;
            go_q       <= 1'b1;
            lfsr_q     <= SEED;
            div_q      <= '0;
            count_q    <= '0;
            idle_q     <= '0;
            random_q   <= '0;
            mole_clk_q <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            rounds_q   <= ROUNDS_INIT;
        end else begin
            state_q    <= state_d;
            go_s_q     <= bus.go;
            go_q       <= go_s_q;
            lfsr_q     <= lfsr_d;
            div_q      <= div_d;
            count_q    <= count_d;
            idle_q     <= idle_d;
            random_q   <= random_d;
            mole_clk_q <= mole_clk_d;
            active_q   <= active_d;
            done_q     <= done_d;
            rounds_q   <= rounds_d;
        end
    end

    assign bus.mole_clk    = mole_clk_q;
    assign bus.count       = count_q;
    assign bus.idle        = idle_q;
    assign bus.random      = random_q;
    assign bus.active      = active_q;
    assign bus.done        = done_q;
    assign bus.rounds_left = rounds_q;
endmodule

// File: tb/tb_mole_sequencer.sv
// Bench for mole_sequencer: random button/reset stimulus against a timeline model of the game
// (elapsed-cycle arithmetic plus a software LFSR stepped from SEED since reset).
module tb_mole_sequencer;
    localparam int         PERIOD   = 8;
    localparam int         IDLE_DIV = 4;
    localparam int         ROUNDS   = 3;
    localparam logic [9:0] SEED     = 10'h2A5;

    typedef enum int {M_IDLE, M_PLAY, M_OVER} mode_e;

    logic clk = 1'b0;
    logic rst;

    mole_sequencer_if bus_if ();

    mole_sequencer #(
        .PERIOD  (PERIOD),
        .IDLE_DIV(IDLE_DIV),
        .ROUNDS  (ROUNDS),
        .SEED    (SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: elapsed cycles per phase, software LFSR, button history.
    mode_e      m_mode = M_IDLE;
    int         m_k = 0;
    int         m_t = 0;
    logic [3:0] m_idle_held = '0;
    logic [9:0] m_rnd = '0;
    logic [9:0] m_lfsr = SEED;
    logic       m_s1 = 1'b1;
    logic       m_s2 = 1'b1;
    logic       m_done = 1'b0;
    logic [7:0] m_rounds = 8'(ROUNDS);
    logic       m_rounds_known = 1'b1;
    int         cyc = 0;
    int         n_strobe = 0;
    int         last_strobe = 0;

    function automatic logic [9:0] lfsr_next(input logic [9:0] l);
        if (l == 10'd0) return SEED;
        return {l[8:0], l[9] ^ l[6]};
    endfunction

    function automatic logic [9:0] pat_of(input logic [9:0] l);
`ifdef MOLE_SPARSE_EN
        logic [9:0] p;
        p = '0;
        for (int i = 0; i < 10; i++) p[i] = l[i] & l[(i + 5) % 10];
        if (p == '0) p[int'(l[3:0]) % 10] = 1'b1;
        return p;
`else
        return l;
`endif
    endfunction

    task automatic model_step();
        logic start;
        m_done = 1'b0;
        if (!rst) begin
            m_mode         = M_IDLE;
            m_k            = 0;
            m_t            = 0;
            m_idle_held    = '0;
            m_rnd          = '0;
            m_rounds       = 8'(ROUNDS);
            m_rounds_known = 1'b1;
            m_lfsr         = SEED;
            m_s1           = 1'b1;
            m_s2           = 1'b1;
            n_strobe       = 0;
        end else begin
            start = m_s1 & ~m_s2;
            case (m_mode)
                M_IDLE: begin
                    if (start) begin
                        m_mode         = M_PLAY;
                        m_t            = 0;
                        m_idle_held    = 4'((m_k / IDLE_DIV) % 10);
                        m_rnd          = pat_of(m_lfsr);
                        m_rounds       = 8'(ROUNDS - 1);
                        m_rounds_known = 1'b1;
                        n_strobe       = 0;
                    end else begin
                        m_k++;
                    end
                end
                M_PLAY: begin
                    m_t++;
                    if (m_t == ROUNDS * PERIOD) begin
                        m_mode   = M_OVER;
                        m_done   = 1'b1;
                        m_rnd    = '0;
                        m_rounds = '0;
                    end else if (m_t % PERIOD == 0) begin
                        m_rnd    = pat_of(m_lfsr);
                        m_rounds = 8'(ROUNDS - 1 - m_t / PERIOD);
                    end
                end
                default: begin
                    if (start) begin
                        m_mode         = M_IDLE;
                        m_k            = 0;
                        m_rounds_known = 1'b0;
                    end
                end
            endcase
            m_s2   = m_s1;
            m_s1   = bus_if.go;
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic compare_outputs();
        int exp_count;
        int exp_idle;
        exp_count = (m_mode == M_PLAY) ? m_t % PERIOD : 0;
        exp_idle  = (m_mode == M_IDLE) ? (m_k / IDLE_DIV) % 10 : int'(m_idle_held);
        check("count", 32'(bus_if.count), 32'(exp_count));
        check("idle", 32'(bus_if.idle), 32'(exp_idle));
        check("mole_clk", 32'(bus_if.mole_clk), 32'(m_mode == M_PLAY && m_t % PERIOD == 0));
        check("random", 32'(bus_if.random), 32'(m_rnd));
        check("active", 32'(bus_if.active), 32'(m_mode == M_PLAY));
        check("done", 32'(bus_if.done), 32'(m_done));
        if (m_rounds_known) check("rounds_left", 32'(bus_if.rounds_left), 32'(m_rounds));
        check("strobe_done_excl", 32'(bus_if.mole_clk & bus_if.done), 32'd0);
        if (bus_if.mole_clk) begin
            check("random_nonzero", 32'(bus_if.random != '0), 32'd1);
            n_strobe++;
            last_strobe = cyc;
        end
        if (bus_if.done) begin
            check("strobes_per_game", 32'(n_strobe), 32'(ROUNDS));
            check("done_gap", 32'(cyc - last_strobe), 32'(PERIOD));
            n_strobe = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            compare_outputs();
        end
    end

    task automatic press(input int n);
        bus_if.go = 1'b1;
        repeat (n) @(negedge clk);
        bus_if.go = 1'b0;
    endtask

    task automatic wait_mode(input mode_e m, input int budget, input string tag);
        int n = 0;
        while (m_mode != m && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(m_mode == m), 32'd1);
    endtask

    task automatic wait_play_t(input int t, input int budget);
        int n = 0;
        while (!(m_mode == M_PLAY && m_t == t) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_play_t", 32'(m_mode == M_PLAY && m_t == t), 32'd1);
    endtask

    initial begin
        rst       = 1'b0;
        bus_if.go = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Idle animation through a full 0..9,0 wrap.
        repeat (45) @(negedge clk);

        // Full game from a 3-cycle press.
        press(3);
        wait_mode(M_OVER, 60, "game1_over");
        repeat (3) @(negedge clk);

        // Back to idle from OVER, then a second game with button noise during play.
        press(2);
        wait_mode(M_IDLE, 10, "over_to_idle");
        repeat ($urandom_range(5, 20)) @(negedge clk);
        press(3);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            bus_if.go = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus_if.go = 1'b0;
        wait_mode(M_OVER, 60, "game2_over");

        // Button held through reset release must not start a game.
        bus_if.go = 1'b1;
        rst       = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("held_no_start", 32'(bus_if.active), 32'd0);
        bus_if.go = 1'b0;
        @(negedge clk);
        press(2);
        @(negedge clk);
        check("held_then_press", 32'(bus_if.active), 32'd1);

        // Reset at count 5 of the second interval aborts the game without done.
        wait_play_t(PERIOD + 5, 40);
        check("mg_count_before", 32'(bus_if.count), 32'd5);
        rst = 1'b0;
        @(negedge clk);
        check("mg_active", 32'(bus_if.active), 32'd0);
        check("mg_done", 32'(bus_if.done), 32'd0);
        check("mg_count", 32'(bus_if.count), 32'd0);
        check("mg_rounds", 32'(bus_if.rounds_left), 32'(ROUNDS));
        rst = 1'b1;
        repeat (6) @(negedge clk);

        // Randomised button levels with occasional resets.
        for (int it = 0; it < 40; it++) begin
            bus_if.go = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
            repeat ($urandom_range(1, 14)) @(negedge clk);
        end
        rst       = 1'b1;
        bus_if.go = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
